// File: rtl/overture_pkg.sv
// Shared encodings for the overture sequencer: instruction fields, modes,
// FSM states and the special port codes used by COPY.
package overture_pkg;

  localparam int MODE_MSB = 7;
  localparam int MODE_LSB = 6;
  localparam int SRC_MSB  = 5;
  localparam int SRC_LSB  = 3;
  localparam int DST_MSB  = 2;
  localparam int DST_LSB  = 0;

  localparam logic [2:0] IN_PORT  = 3'd6;
  localparam logic [2:0] OUT_PORT = 3'd7;

  // Fixed register roles of the IMM, CALC and COND instructions
  localparam logic [2:0] IMM_DST   = 3'd0;
  localparam logic [2:0] CALC_SRC1 = 3'd1;
  localparam logic [2:0] CALC_SRC2 = 3'd2;
  localparam logic [2:0] CALC_DST  = 3'd3;
  localparam logic [2:0] COND_REG  = 3'd3;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_CALC = 2'b01,
    MODE_COPY = 2'b10,
    MODE_COND = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_ALU_WAIT,
    ST_WRITE,
    ST_EVAL
  } state_e;

endpackage

// File: rtl/overture_decode.sv
// Combinational instruction decoder: splits the byte into mode/src/dst and
// flags COPY instructions that read the output port or write the input port.
module overture_decode
  import overture_pkg::*;
(
  input  logic [7:0] i_instr,
  output mode_e      o_mode,
  output logic [2:0] o_src,
  output logic [2:0] o_dst,
  output logic       o_legal
);

  assign o_mode  = mode_e'(i_instr[MODE_MSB:MODE_LSB]);
  assign o_src   = i_instr[SRC_MSB:SRC_LSB];
  assign o_dst   = i_instr[DST_MSB:DST_LSB];
  assign o_legal = (o_mode != MODE_COPY) || ((o_src != OUT_PORT) && (o_dst != IN_PORT));

endmodule

// File: rtl/overture_sequencer.sv
// Register-file control sequencer: accepts one instruction at a time and
// drives load/save enables and strobes until the instruction retires.
module overture_sequencer
  import overture_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int NREG    = 6
) (
  input  logic            clk,
  input  logic            res,
  input  logic [7:0]      instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [NREG-1:0] load1_en,
  output logic [NREG-1:0] load2_en,
  output logic [NREG-1:0] save_en,
  output logic            imm_en,
  output logic [7:0]      imm_value,
  output logic            in_en,
  output logic            out_en,
  output logic [2:0]      alu_op,
  output logic [2:0]      cond_op,
  input  logic            cond_true,
  output logic            jump,
  output logic            done,
  output logic            illegal,
  output logic            busy
);

  localparam logic [2:0]      LAT_M1 = 3'(ALU_LAT - 1);
  localparam logic [NREG-1:0] ONE    = {{(NREG-1){1'b0}}, 1'b1};

  state_e     r_state, w_next;
  mode_e      r_mode, w_mode;
  logic [2:0] r_src, r_dst, w_src, w_dst;
  logic [5:0] r_imm;
  logic [2:0] r_cnt;
  logic       r_illegal;
  logic       w_legal, w_accept;

  overture_decode u_decode (
    .i_instr (instr),
    .o_mode  (w_mode),
    .o_src   (w_src),
    .o_dst   (w_dst),
    .o_legal (w_legal)
  );

  assign w_accept = (r_state == ST_IDLE) && instr_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_mode    <= MODE_IMM;
      r_src     <= '0;
      r_dst     <= '0;
      r_imm     <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_mode <= w_mode;
        r_src  <= w_src;
        r_dst  <= w_dst;
        r_imm  <= instr[5:0];
      end
      if (r_state == ST_READ)                       r_cnt <= LAT_M1;
      else if (r_state == ST_ALU_WAIT && r_cnt != 0) r_cnt <= r_cnt - 3'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (instr_valid && w_legal) w_next = (w_mode == MODE_IMM) ? ST_WRITE : ST_READ;
      ST_READ: begin
        unique case (r_mode)
          MODE_CALC: w_next = ST_ALU_WAIT;
          MODE_COND: w_next = ST_EVAL;
          default:   w_next = ST_WRITE;
        endcase
      end
      ST_ALU_WAIT: if (r_cnt == 3'd0) w_next = ST_WRITE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched fields
  always_comb begin
    load1_en = '0;
    load2_en = '0;
    save_en  = '0;
    imm_en   = 1'b0;
    in_en    = 1'b0;
    out_en   = 1'b0;
    jump     = 1'b0;
    alu_op   = 3'd0;
    cond_op  = 3'd0;
    if (r_state != ST_IDLE) begin
      unique case (r_mode)
        MODE_IMM: begin
          if (r_state == ST_WRITE) begin
            imm_en  = 1'b1;
            save_en = ONE << IMM_DST;
          end
        end
        MODE_CALC: begin
          alu_op   = r_dst;
          load1_en = ONE << CALC_SRC1;
          load2_en = ONE << CALC_SRC2;
          if (r_state == ST_WRITE) save_en = ONE << CALC_DST;
        end
        MODE_COPY: begin
          if (r_src == IN_PORT) in_en = 1'b1;
          else                  load1_en = ONE << r_src;
          if (r_state == ST_WRITE) begin
            if (r_dst == OUT_PORT) out_en = 1'b1;
            else                   save_en = ONE << r_dst;
          end
        end
        MODE_COND: begin
          cond_op  = r_dst;
          load1_en = ONE << COND_REG;
          jump     = (r_state == ST_EVAL) && cond_true;
        end
      endcase
    end
  end

  assign imm_value   = {2'b00, r_imm};
  assign instr_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign illegal     = r_illegal;
  assign done        = (r_state == ST_WRITE) || (r_state == ST_EVAL) || r_illegal;

endmodule

// File: doc/overture_sequencer.md
# overture_sequencer

Control sequencer for the register-file datapath of the model computer. It accepts one 8-bit instruction at a time and drives the per-register load1/load2/save enables plus the immediate, I/O, ALU and condition strobes for the required number of cycles, so that operands appear on the two tri-state buses, the result is written back, and one instruction completes before the next is accepted. It sits between instruction fetch and the six general registers (R0–R5).

## Interface
- ALU_LAT, 1, ALU result latency in cycles after operands are on the buses (legal 1–7)
- NREG, 6, number of general registers (codes 0..NREG-1; code 6 = input port, code 7 = output port)

- clk  in  1  system clock, all state changes on rising edge
- res  in  1  reset, asynchronous, active-low
- instr  in  8  instruction byte: [7:6] mode, [5:3] src, [2:0] dst/op
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer idle, will accept instr this cycle
- load1_en  out  NREG  one-hot, drive register onto bus 1
- load2_en  out  NREG  one-hot, drive register onto bus 2
- save_en  out  NREG  one-hot, write result bus into register
- imm_en  out  1  drive imm_value onto result bus
- imm_value  out  8  {2'b00, instr[5:0]} of the current instruction
- in_en  out  1  input port drives bus 1
- out_en  out  1  output port latches bus 1
- alu_op  out  3  ALU operation (instr[2:0]) held for the whole CALC instruction
- cond_op  out  3  condition code (instr[2:0]) held for the whole COND instruction
- cond_true  in  1  condition unit result, sampled in EVAL
- jump  out  1  one-cycle pulse: condition met
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  one-cycle pulse: illegal COPY, no write performed
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, READ, ALU_WAIT, WRITE, EVAL.
- IDLE: instr_ready=1; on instr_valid the instruction is latched and decoded; next state per mode below. All enables 0 in IDLE.
- Mode 00 IMM: IDLE→WRITE; WRITE asserts imm_en and save_en[0] for one cycle.
- Mode 01 CALC: IDLE→READ (load1_en[1], load2_en[2]) →ALU_WAIT (load1/load2 held, counter ALU_LAT-1 down to 0) →WRITE (load1/load2 held, save_en[3]).
- Mode 10 COPY: src∈{0..5,6}, dst∈{0..5,7}. IDLE→READ (load1_en[src] or in_en) →WRITE (source enable held; save_en[dst] or out_en). src=7 or dst=6: IDLE→IDLE, illegal pulses with done, no enables asserted. src=dst is legal.
- Mode 11 COND: IDLE→READ (load1_en[3]) →EVAL (load1_en[3] held, cond_true sampled); jump=cond_true for that cycle.
- WRITE and EVAL always return to IDLE with done=1 in that same cycle.
- At most one bit set in each one-hot vector; save_en never asserted together with instr_ready.
- Reset (res=0) at any time: state IDLE, counter 0, all enables, jump, done, illegal, busy = 0, instr_ready = 1 after release; a partially executed instruction is abandoned without any write.

## Timing
- All outputs registered from state; no combinational path instr→enables.
- Accept at edge 0. Cycle counts until done (inclusive): IMM 1, COPY 2, COND 2, CALC 2+ALU_LAT.
- Registers present bus data one edge after load enable; hence the load enable is asserted at least one cycle before the save/eval cycle and held through it.
- instr_ready high in the cycle after done; back-to-back instructions lose no cycle beyond this.
- instr_valid while busy is ignored (not latched).

## Structure
- Package overture_pkg: mode encodings (IMM/CALC/COPY/COND), state enum, register codes (IN_PORT=6, OUT_PORT=7), field slice positions.
- Sub-module overture_decode: combinational instr → {mode, src, dst, legal}; sequencer holds state machine and latency counter.

## Test plan
- IMM 8'h2A accepted → next cycle imm_en=1, imm_value=8'h2A, save_en=6'b000001, done=1; ready again after.
- CALC 8'h44, ALU_LAT=3 → load1_en=000010, load2_en=000100 for 5 cycles, save_en=001000 in cycle 5 only, alu_op=3'b100 throughout, done in cycle 5.
- COPY 8'h8C (R1→R4) → load1_en=000010 cycles 1–2, save_en=010000 cycle 2; COPY 8'hB7 (in→out) → in_en cycles 1–2, out_en cycle 2.
- COPY 8'hBE (src 7) and 8'h86 (dst 6) → illegal=1 and done=1 in cycle 1, no enables ever asserted.
- COND 8'hC2 with cond_true=1 then repeat with 0 → load1_en=001000 cycles 1–2, jump=1 only in first run's cycle 2, cond_op=3'b010.
- CALC with ALU_LAT=7, res pulled low in ALU_WAIT → all outputs 0 immediately, no save_en; instr_valid held during busy is not latched.
